// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types: word/register-select widths, ALU opcodes and ALU port-B source encoding.
package cpu_types_pkg;

    localparam int WORD_BITS = 32;
    localparam int REG_BITS  = 5;

    typedef logic [WORD_BITS-1:0] word_t;
    typedef logic [REG_BITS-1:0]  regbits_t;

    typedef enum logic [3:0] {
        ALU_SLL   = 4'h0,
        ALU_SRL   = 4'h1,
        ALU_SRA   = 4'h2,
        ALU_ADD   = 4'h3,
        ALU_ADDU  = 4'h4,
        ALU_SUB   = 4'h5,
        ALU_SUBU  = 4'h6,
        ALU_AND   = 4'h7,
        ALU_OR    = 4'h8,
        ALU_XOR   = 4'h9,
        ALU_NOR   = 4'ha,
        ALU_SLT   = 4'hb,
        ALU_SLTU  = 4'hc,
        ALU_LUI   = 4'hd,
        ALU_RSV14 = 4'he,
        ALU_RSV15 = 4'hf
    } aluop_t;

    // Encoding 3 is unused by decode and behaves like BSRC_REG.
    typedef enum logic [1:0] {
        BSRC_REG   = 2'd0,
        BSRC_IMM   = 2'd1,
        BSRC_SHAMT = 2'd2,
        BSRC_RSV   = 2'd3
    } bsrc_t;

endpackage

// File: rtl/forward_mux.sv
// forward_mux: combinational operand bypass for one source select; r0 always reads as zero.
// With FORWARDING_EN, MEM results win over WB results, which win over register-file data.
module forward_mux
    import cpu_types_pkg::*;
#(
    parameter int WORD_W = WORD_BITS,
    parameter int REG_AW = REG_BITS
) (
    input  logic [REG_AW-1:0] i_sel,
    input  logic [WORD_W-1:0] i_dat,
    input  logic [REG_AW-1:0] i_mem_wsel,
    input  logic              i_mem_wen,
    input  logic [WORD_W-1:0] i_mem_wdat,
    input  logic [REG_AW-1:0] i_wb_wsel,
    input  logic              i_wb_wen,
    input  logic [WORD_W-1:0] i_wb_wdat,
    output logic [WORD_W-1:0] o_dat
);

`ifdef FORWARDING_EN
    always_comb begin
        if (i_sel == '0) begin
            o_dat = '0;
        end else if (i_mem_wen && (i_mem_wsel == i_sel)) begin
            o_dat = i_mem_wdat;
        end else if (i_wb_wen && (i_wb_wsel == i_sel)) begin
            o_dat = i_wb_wdat;
        end else begin
            o_dat = i_dat;
        end
    end
`else
    // Without bypassing the hazard logic stalls instead, so the bypass inputs are dead here.
    logic w_unused_bypass;
    assign w_unused_bypass = ^{i_mem_wsel, i_mem_wen, i_mem_wdat, i_wb_wsel, i_wb_wen, i_wb_wdat};
    assign o_dat = (i_sel == '0) ? '0 : i_dat;
`endif

endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX register, operand select and load-use stall; fields appear one edge after sampling, ex_hold freezes.
// FORWARDING_EN enables MEM/WB bypass; without it, RAW hazards against EX and MEM also stall decode.
module id_ex_stage
    import cpu_types_pkg::*;
#(
    parameter int WORD_W = WORD_BITS,
    parameter int REG_AW = REG_BITS
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              id_valid,
    input  logic [3:0]        id_aluop,
    input  logic [REG_AW-1:0] id_rsel1,
    input  logic [REG_AW-1:0] id_rsel2,
    input  logic [WORD_W-1:0] id_rdat1,
    input  logic [WORD_W-1:0] id_rdat2,
    input  logic [WORD_W-1:0] id_imm,
    input  logic [4:0]        id_shamt,
    input  logic [1:0]        id_bsrc,
    input  logic [REG_AW-1:0] id_wsel,
    input  logic              id_wen,
    input  logic              id_memread,
    input  logic              ex_hold,
    input  logic              flush,
    input  logic [REG_AW-1:0] mem_wsel,
    input  logic              mem_wen,
    input  logic [WORD_W-1:0] mem_wdat,
    input  logic [REG_AW-1:0] wb_wsel,
    input  logic              wb_wen,
    input  logic [WORD_W-1:0] wb_wdat,
    output logic              id_stall,
    output logic [3:0]        ALUOP,
    output logic [WORD_W-1:0] Port_A,
    output logic [WORD_W-1:0] Port_B,
    output logic              ex_valid,
    output logic              ex_wen,
    output logic              ex_memread,
    output logic [REG_AW-1:0] ex_wsel,
    output logic [WORD_W-1:0] ex_stdat
);

    logic              r_valid;
    aluop_t            r_aluop;
    logic [REG_AW-1:0] r_rsel1;
    logic [REG_AW-1:0] r_rsel2;
    logic [WORD_W-1:0] r_rdat1;
    logic [WORD_W-1:0] r_rdat2;
    logic [WORD_W-1:0] r_imm;
    logic [4:0]        r_shamt;
    bsrc_t             r_bsrc;
    logic [REG_AW-1:0] r_wsel;
    logic              r_wen;
    logic              r_memread;

    logic              w_load;
    logic              w_load_use;
    logic              w_raw;
    logic [WORD_W-1:0] w_fwd1;
    logic [WORD_W-1:0] w_fwd2;

    // Bubbles only need the control bits cleared; datapath fields load regardless.
    assign w_load = id_valid && !flush && !id_stall;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_valid   <= 1'b0;
            r_aluop   <= ALU_SLL;
            r_rsel1   <= '0;
            r_rsel2   <= '0;
            r_rdat1   <= '0;
            r_rdat2   <= '0;
            r_imm     <= '0;
            r_shamt   <= '0;
            r_bsrc    <= BSRC_REG;
            r_wsel    <= '0;
            r_wen     <= 1'b0;
            r_memread <= 1'b0;
        end else if (!ex_hold) begin
            r_valid   <= w_load;
            r_aluop   <= w_load ? aluop_t'(id_aluop) : ALU_SLL;
            r_rsel1   <= id_rsel1;
            r_rsel2   <= id_rsel2;
            r_rdat1   <= id_rdat1;
            r_rdat2   <= id_rdat2;
            r_imm     <= id_imm;
            r_shamt   <= id_shamt;
            r_bsrc    <= bsrc_t'(id_bsrc);
            r_wsel    <= id_wsel;
            r_wen     <= w_load && id_wen;
            r_memread <= w_load && id_memread;
        end
    end

    forward_mux #(.WORD_W(WORD_W), .REG_AW(REG_AW)) u_fwd1 (
        .i_sel      (r_rsel1),
        .i_dat      (r_rdat1),
        .i_mem_wsel (mem_wsel),
        .i_mem_wen  (mem_wen),
        .i_mem_wdat (mem_wdat),
        .i_wb_wsel  (wb_wsel),
        .i_wb_wen   (wb_wen),
        .i_wb_wdat  (wb_wdat),
        .o_dat      (w_fwd1)
    );

    forward_mux #(.WORD_W(WORD_W), .REG_AW(REG_AW)) u_fwd2 (
        .i_sel      (r_rsel2),
        .i_dat      (r_rdat2),
        .i_mem_wsel (mem_wsel),
        .i_mem_wen  (mem_wen),
        .i_mem_wdat (mem_wdat),
        .i_wb_wsel  (wb_wsel),
        .i_wb_wen   (wb_wen),
        .i_wb_wdat  (wb_wdat),
        .o_dat      (w_fwd2)
    );

    // Shifts take the shifted value from rt, so SHAMT moves the rt operand onto port A.
    always_comb begin
        Port_A = w_fwd1;
        Port_B = w_fwd2;
        case (r_bsrc)
            BSRC_IMM:   Port_B = r_imm;
            BSRC_SHAMT: begin
                Port_A = w_fwd2;
                Port_B = {{(WORD_W-5){1'b0}}, r_shamt};
            end
            default:    ;
        endcase
    end

    assign w_load_use = id_valid && r_valid && r_memread && (r_wsel != '0) &&
                        ((r_wsel == id_rsel1) || (r_wsel == id_rsel2));

`ifdef FORWARDING_EN
    assign w_raw = 1'b0;
`else
    logic w_busy1;
    logic w_busy2;
    assign w_busy1 = (id_rsel1 != '0) &&
                     ((r_valid && r_wen && (r_wsel == id_rsel1)) || (mem_wen && (mem_wsel == id_rsel1)));
    assign w_busy2 = (id_rsel2 != '0) &&
                     ((r_valid && r_wen && (r_wsel == id_rsel2)) || (mem_wen && (mem_wsel == id_rsel2)));
    assign w_raw   = id_valid && (w_busy1 || w_busy2);
`endif

    assign id_stall   = w_load_use || w_raw;
    assign ALUOP      = r_aluop;
    assign ex_valid   = r_valid;
    assign ex_wen     = r_wen;
    assign ex_memread = r_memread;
    assign ex_wsel    = r_wsel;
    assign ex_stdat   = w_fwd2;

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

Decode-to-execute pipeline register and operand-select stage. It latches decoded fields and register-file read data, resolves forwarding from the MEM and WB stages, and drives the ALU's ALUOP, Port_A and Port_B directly. It also detects load-use hazards and inserts one-cycle bubbles, holding decode while it does so.

## Interface
- WORD_W, 32, datapath width
- REG_AW, 5, register-select width
- CLK  in  1  rising-edge clock
- nRST  in  1  asynchronous active-low reset
- id_valid  in  1  decode presents an instruction
- id_aluop  in  4  aluop_t
- id_rsel1, id_rsel2  in  REG_AW  source selects (rs, rt)
- id_rdat1, id_rdat2  in  WORD_W  register-file read data
- id_imm  in  WORD_W  extended immediate
- id_shamt  in  5  shift amount
- id_bsrc  in  2  bsrc_t: 0 REG, 1 IMM, 2 SHAMT, 3 treated as REG
- id_wsel  in  REG_AW; id_wen  in  1; id_memread  in  1 (load)
- ex_hold  in  1  downstream stall; register keeps contents
- flush  in  1  kill the instruction entering EX
- mem_wsel  in  REG_AW; mem_wen  in  1; mem_wdat  in  WORD_W
- wb_wsel  in  REG_AW; wb_wen  in  1; wb_wdat  in  WORD_W
- id_stall  out  1  decode/PC must hold
- ALUOP  out  4; Port_A, Port_B  out  WORD_W
- ex_valid, ex_wen, ex_memread  out  1; ex_wsel  out  REG_AW
- ex_stdat  out  WORD_W  forwarded rt value for stores

## Operation
- Registered fields: valid, aluop, rsel1/2, rdat1/2, imm, shamt, bsrc, wsel, wen, memread.
- Load priority at each edge:
  - ex_hold: hold all fields. Flush and stall are ignored; decode keeps flush asserted.
  - flush or id_stall or !id_valid: load a bubble, i.e. valid=0, wen=0, memread=0, aluop=4'h0, other fields don't-care.
  - Otherwise load the id_* fields.
- Forward fwd(sel, dat): if sel==0, return 0. Else if mem_wen && mem_wsel==sel, return mem_wdat. Else if wb_wen && wb_wsel==sel, return wb_wdat. Else return dat. MEM has priority over WB.
- Operand select by bsrc:
  - REG: Port_A = fwd(rsel1), Port_B = fwd(rsel2).
  - IMM: Port_A = fwd(rsel1), Port_B = imm.
  - SHAMT: Port_A = fwd(rsel2), Port_B = {27'b0, shamt}.
- ex_stdat = fwd(rsel2). Fields ALUOP, ex_wsel, ex_wen, ex_memread and ex_valid come straight from the register.
- id_stall (load-use) = id_valid & ex_valid & ex_memread & ex_wsel!=0 & (ex_wsel==id_rsel1 | ex_wsel==id_rsel2). The comparison is conservative and ignores bsrc.

## Timing
- Reset: every register cleared, so all outputs are 0, including ALUOP=4'h0 and Port_A=Port_B=0.
- Latency: id_* fields sampled at edge N appear on the outputs after edge N. Forwarding and the operand muxes are combinational in EX.
- Load-use costs one bubble. id_stall drops the cycle after the bubble enters, because ex_memread is then 0.
- id_stall is combinational and still asserts during ex_hold. Decode must hold whenever id_stall or ex_hold is high.
- Register 0 is never forwarded and never triggers a stall.

## Configuration
- FORWARDING_EN defined: behaviour as above.
- FORWARDING_EN undefined:
  - fwd() returns dat, or 0 for register 0.
  - id_stall additionally asserts when an ID source (nonzero) matches ex_wsel with ex_wen & ex_valid, or matches mem_wsel with mem_wen.
  - The register file writes in the first half-cycle, so WB needs no check.

## Structure
- cpu_types_pkg holds aluop_t, the new bsrc_t enum, regbits_t and word_t.
- One sub-module, forward_mux, implements fwd(). It is instantiated twice, for rsel1 and rsel2; the rsel2 instance supplies both Port_B (REG) and ex_stdat.

## Test plan
- Reset mid-run with nRST low asynchronously → all outputs 0 immediately, before the next CLK edge.
- ADD r3←r1,r2 with rdat1=5, rdat2=7; next cycle mem_wsel=1, mem_wen=1, mem_wdat=100, wb_wsel=1, wb_wen=1, wb_wdat=9 → Port_A=100 (MEM wins), Port_B=7.
- LW r4 followed by ADD r5←r4,r6 → id_stall=1 for exactly one cycle, then a bubble with ex_valid=0, ex_wen=0, then the ADD enters EX.
- SLL with rt=r2=0x1, shamt=4, bsrc=SHAMT → Port_A=0x1, Port_B=4.
- flush and ex_hold high together → contents unchanged; flush alone next cycle → ex_valid=0.
- Source r0 with mem_wsel=0, mem_wen=1, mem_wdat=0xFFFF → Port_A=0 and no stall.
